// File: rtl/lane_os_counter_bank.sv
// Per-lane consecutive ordered-set counters feeding the RX LTSSM.
// Each lane counts qualifying TS1/TS2/IDLE sets and flags when the requested run length is reached.
module lane_os_counter_bank #(
   parameter int MAXLANES = 16,
   parameter int CNTW     = 5
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [3:0]               substate,
   input  logic [4:0]               comparatorsCount,
   input  logic [MAXLANES-1:0]      resetOsCheckers,
   input  logic [MAXLANES-1:0]      osValid,
   input  logic [3*MAXLANES-1:0]    osType,
   input  logic [8*MAXLANES-1:0]    osLinkNum,
   input  logic [MAXLANES-1:0]      osLinkPad,
   input  logic [MAXLANES-1:0]      osLanePad,
   output logic [MAXLANES-1:0]      countersComparators,
   output logic [CNTW*MAXLANES-1:0] laneCount
);

   typedef enum logic [3:0] {
      DETECT_QUIET      = 4'd0,
      DETECT_ACTIVE     = 4'd1,
      POLLING_ACTIVE    = 4'd2,
      POLLING_CONFIG    = 4'd3,
      LINK_WIDTH_START  = 4'd4,
      LINK_WIDTH_ACCEPT = 4'd5,
      LANENUM_WAIT      = 4'd6,
      LANENUM_ACCEPT    = 4'd7,
      CONFIG_COMPLETE   = 4'd8,
      CONFIG_IDLE       = 4'd9
   } substate_t;

   typedef enum logic [2:0] {
      OS_OTHER = 3'd0,
      OS_TS1   = 3'd1,
      OS_TS2   = 3'd2,
      OS_SKP   = 3'd3,
      OS_EIOS  = 3'd4,
      OS_EIEOS = 3'd5,
      OS_IDLE  = 3'd6
   } osType_t;

   logic [MAXLANES-1:0][CNTW-1:0] cnt, cntNext;
   logic [MAXLANES-1:0][7:0]      linkCap, capNext;
   logic [MAXLANES-1:0]           cmpNext;
   logic [3:0]                    substateQ;
   logic [CNTW-1:0]               thr;
   logic                          subChange;
   logic                          linkTracked;

   function automatic logic qualifies(input logic [3:0] sub, input logic [2:0] typ,
                                      input logic linkPad, input logic lanePad);
      logic q;
      q = 1'b0;
      case (sub)
         POLLING_ACTIVE:    q = (typ == OS_TS1 || typ == OS_TS2) && linkPad && lanePad;
         POLLING_CONFIG:    q = (typ == OS_TS2) && linkPad && lanePad;
         LINK_WIDTH_START:  q = (typ == OS_TS1) && !linkPad && lanePad;
         LINK_WIDTH_ACCEPT: q = (typ == OS_TS1) && !linkPad && !lanePad;
         LANENUM_WAIT, LANENUM_ACCEPT, CONFIG_COMPLETE:
                            q = (typ == OS_TS2) && !linkPad && !lanePad;
         CONFIG_IDLE:       q = (typ == OS_IDLE);
         default:           q = 1'b0;
      endcase
      return q;
   endfunction

   assign thr         = CNTW'(comparatorsCount);
   assign subChange   = (substate != substateQ);
   assign linkTracked = (substate >= LINK_WIDTH_START) && (substate <= CONFIG_COMPLETE);
   assign laneCount   = cnt;

   always_comb begin
      cntNext = cnt;
      capNext = linkCap;
      cmpNext = '0;
      for (int unsigned i = 0; i < MAXLANES; i++) begin
         if (!resetOsCheckers[i] || subChange) begin
            cntNext[i] = '0;
         end else if (!osValid[i]) begin
            cntNext[i] = cnt[i];
         end else if (osType[3*i +: 3] == OS_SKP || osType[3*i +: 3] == OS_EIEOS) begin
            cntNext[i] = cnt[i];
         end else if (qualifies(substate, osType[3*i +: 3], osLinkPad[i], osLanePad[i])) begin
            // In link-number substates a run only continues while the link number is stable.
            if (linkTracked && (cnt[i] == '0 || osLinkNum[8*i +: 8] != linkCap[i])) begin
               cntNext[i] = CNTW'(1);
               capNext[i] = osLinkNum[8*i +: 8];
            end else if (cnt[i] != '1) begin
               cntNext[i] = cnt[i] + 1'b1;
            end
         end else begin
            cntNext[i] = '0;
         end
         cmpNext[i] = resetOsCheckers[i] && (cntNext[i] >= thr);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt                 <= '0;
         linkCap             <= '0;
         countersComparators <= '0;
         substateQ           <= '1;
      end else begin
         cnt                 <= cntNext;
         linkCap             <= capNext;
         countersComparators <= cmpNext;
         substateQ           <= substate;
      end
   end

endmodule

// File: tb/tb_lane_os_counter_bank.sv
// Bench for lane_os_counter_bank: directed vector table, then randomized traffic
// checked against a per-lane behavioural model.
module tb_lane_os_counter_bank;
   localparam int NL = 16;
   localparam int CW = 5;
   localparam int TS1 = 1, TS2 = 2, SKP = 3, EIOS = 4, EIEOS = 5, IDLE = 6;

   logic             clk = 1'b0;
   logic             reset;
   logic [3:0]       substate;
   logic [4:0]       comparatorsCount;
   logic [NL-1:0]    resetOsCheckers;
   logic [NL-1:0]    osValid;
   logic [3*NL-1:0]  osType;
   logic [8*NL-1:0]  osLinkNum;
   logic [NL-1:0]    osLinkPad;
   logic [NL-1:0]    osLanePad;
   logic [NL-1:0]    countersComparators;
   logic [CW*NL-1:0] laneCount;

   lane_os_counter_bank #(.MAXLANES(NL), .CNTW(CW)) dut (
      .clk                 (clk),
      .reset               (reset),
      .substate            (substate),
      .comparatorsCount    (comparatorsCount),
      .resetOsCheckers     (resetOsCheckers),
      .osValid             (osValid),
      .osType              (osType),
      .osLinkNum           (osLinkNum),
      .osLinkPad           (osLinkPad),
      .osLanePad           (osLanePad),
      .countersComparators (countersComparators),
      .laneCount           (laneCount)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int          sub;
      int          thr;
      logic [15:0] en;
      bit          vld;
      int          lane;
      int          typ;
      int          link;
      bit          lkPad;
      bit          lnPad;
      int          expCnt;
      logic [15:0] expBits;
   } vec_t;

   vec_t vecs[$];

   int          mCnt[NL];
   int          mCap[NL];
   logic [NL-1:0] mCmp;
   int          mSubQ;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void addV(int sub, int thr, logic [15:0] en, bit vld, int lane, int typ,
                                int link, bit lkPad, bit lnPad, int expCnt, logic [15:0] expBits);
      vec_t v;
      v.sub = sub; v.thr = thr; v.en = en; v.vld = vld; v.lane = lane; v.typ = typ;
      v.link = link; v.lkPad = lkPad; v.lnPad = lnPad; v.expCnt = expCnt; v.expBits = expBits;
      vecs.push_back(v);
   endfunction

   function automatic bit modelQual(int sub, int typ, bit lkPad, bit lnPad);
      case (sub)
         2:       return (typ == TS1 || typ == TS2) && lkPad && lnPad;
         3:       return typ == TS2 && lkPad && lnPad;
         4:       return typ == TS1 && !lkPad && lnPad;
         5:       return typ == TS1 && !lkPad && !lnPad;
         6, 7, 8: return typ == TS2 && !lkPad && !lnPad;
         9:       return typ == IDLE;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] prefType(int sub);
      case (sub)
         3, 6, 7, 8: return 3'(TS2);
         9:          return 3'(IDLE);
         default:    return 3'(TS1);
      endcase
   endfunction

   task automatic resetModel();
      for (int i = 0; i < NL; i++) begin
         mCnt[i] = 0;
         mCap[i] = 0;
      end
      mCmp  = '0;
      mSubQ = 15;
   endtask

   // Applies one clock worth of the counting rules to the model using the inputs now driven.
   task automatic modelStep();
      int  sub;
      int  typ;
      int  lk;
      bit  changed;
      sub     = int'(substate);
      changed = (sub != mSubQ);
      for (int i = 0; i < NL; i++) begin
         typ = int'(osType[3*i +: 3]);
         lk  = int'(osLinkNum[8*i +: 8]);
         if (!resetOsCheckers[i] || changed) mCnt[i] = 0;
         else if (!osValid[i]) mCnt[i] = mCnt[i];
         else if (typ == SKP || typ == EIEOS) mCnt[i] = mCnt[i];
         else if (modelQual(sub, typ, osLinkPad[i], osLanePad[i])) begin
            if (sub >= 4 && sub <= 8 && (mCnt[i] == 0 || lk != mCap[i])) begin
               mCnt[i] = 1;
               mCap[i] = lk;
            end else begin
               mCnt[i] = (mCnt[i] + 1 > 31) ? 31 : mCnt[i] + 1;
            end
         end else mCnt[i] = 0;
         mCmp[i] = resetOsCheckers[i] && (mCnt[i] >= int'(comparatorsCount));
      end
      mSubQ = sub;
   endtask

   task automatic compareModel(input string tag);
      logic [CW*NL-1:0] packed_cnt;
      for (int i = 0; i < NL; i++) packed_cnt[CW*i +: CW] = CW'(mCnt[i]);
      check({tag, "_cnt"}, 128'(laneCount), 128'(packed_cnt));
      check({tag, "_cmp"}, 128'(countersComparators), 128'(mCmp));
   endtask

   task automatic applyVec(input vec_t v);
      substate         = 4'(v.sub);
      comparatorsCount = 5'(v.thr);
      resetOsCheckers  = v.en;
      osValid          = '0;
      osType           = '0;
      osLinkNum        = '0;
      osLinkPad        = '0;
      osLanePad        = '0;
      osValid[v.lane]          = v.vld;
      osType[3*v.lane +: 3]    = 3'(v.typ);
      osLinkNum[8*v.lane +: 8] = 8'(v.link);
      osLinkPad[v.lane]        = v.lkPad;
      osLanePad[v.lane]        = v.lnPad;
   endtask

   task automatic randomCycle();
      if ($urandom_range(0, 39) == 0)
         substate = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 29) == 0) comparatorsCount = 5'($urandom_range(0, 12));
      for (int i = 0; i < NL; i++) begin
         resetOsCheckers[i]  = ($urandom_range(0, 24) != 0);
         osValid[i]          = ($urandom_range(0, 9) < 6);
         osType[3*i +: 3]    = ($urandom_range(0, 3) != 0) ? prefType(int'(substate)) : 3'($urandom_range(0, 6));
         osLinkNum[8*i +: 8] = ($urandom_range(0, 19) == 0) ? 8'd4 : 8'd3;
         osLinkPad[i]        = (substate <= 4'd3) ^ ($urandom_range(0, 19) == 0);
         osLanePad[i]        = (substate <= 4'd4) ^ ($urandom_range(0, 19) == 0);
      end
      modelStep();
      @(posedge clk);
      #1;
      compareModel("rnd");
   endtask

   initial begin
      // pollingActive: first cycle clears on the substate change, then 8 TS1 PAD/PAD on lane 3.
      addV(2, 8, 16'hFFFF, 1, 3, TS1, 0, 1, 1, 0, 16'h0000);
      for (int k = 1; k <= 8; k++)
         addV(2, 8, 16'hFFFF, 1, 3, TS1, 0, 1, 1, k, (k == 8) ? 16'h0008 : 16'h0000);
      addV(2, 8, 16'hFFFF, 0, 3, TS1, 0, 1, 1, 8, 16'h0008);
      addV(2, 8, 16'hFFFF, 1, 3, SKP, 0, 1, 1, 8, 16'h0008);
      addV(2, 8, 16'hFFFF, 1, 3, EIOS, 0, 1, 1, 0, 16'h0000);
      // pollingConfiguration run broken by a TS1, EIEOS/SKP transparent.
      addV(3, 8, 16'hFFFF, 1, 0, TS2, 0, 1, 1, 0, 16'h0000);
      for (int k = 1; k <= 5; k++) addV(3, 8, 16'hFFFF, 1, 0, TS2, 0, 1, 1, k, 16'h0000);
      addV(3, 8, 16'hFFFF, 1, 0, EIEOS, 0, 1, 1, 5, 16'h0000);
      addV(3, 8, 16'hFFFF, 1, 0, TS1, 0, 1, 1, 0, 16'h0000);
      addV(3, 8, 16'hFFFF, 1, 0, SKP, 0, 1, 1, 0, 16'h0000);
      for (int k = 1; k <= 3; k++) addV(3, 8, 16'hFFFF, 1, 0, TS2, 0, 1, 1, k, 16'h0000);
      // linkWidthAccept link-number restart on lane 1.
      addV(5, 2, 16'hFFFF, 1, 1, TS1, 7, 0, 0, 0, 16'h0000);
      addV(5, 2, 16'hFFFF, 1, 1, TS1, 7, 0, 0, 1, 16'h0000);
      addV(5, 2, 16'hFFFF, 1, 1, TS1, 9, 0, 0, 1, 16'h0000);
      addV(5, 2, 16'hFFFF, 1, 1, TS1, 9, 0, 0, 2, 16'h0002);
      // Per-lane clear on lane 2 discards the strobe.
      addV(5, 2, 16'hFFFF, 1, 2, TS1, 4, 0, 0, 1, 16'h0002);
      addV(5, 2, 16'hFFFF, 1, 2, TS1, 4, 0, 0, 2, 16'h0006);
      addV(5, 2, 16'hFFFB, 1, 2, TS1, 4, 0, 0, 0, 16'h0002);
      addV(5, 2, 16'hFFFF, 1, 1, TS2, 9, 0, 0, 0, 16'h0000);
      // linkWidthStart run to 2, then substate change clears.
      addV(4, 2, 16'hFFFF, 1, 1, TS1, 7, 0, 1, 0, 16'h0000);
      addV(4, 2, 16'hFFFF, 1, 1, TS1, 7, 0, 1, 1, 16'h0000);
      addV(4, 2, 16'hFFFF, 1, 1, TS1, 7, 0, 1, 2, 16'h0002);
      addV(5, 2, 16'hFFFF, 1, 1, TS1, 7, 0, 0, 0, 16'h0000);
      // configurationIdle saturation and threshold changes.
      addV(9, 8, 16'hFFFF, 1, 5, IDLE, 0, 0, 0, 0, 16'h0000);
      for (int k = 1; k <= 40; k++)
         addV(9, 8, 16'hFFFF, 1, 5, IDLE, 0, 0, 0, (k > 31) ? 31 : k, (k >= 8) ? 16'h0020 : 16'h0000);
      addV(9, 31, 16'hFFFF, 0, 5, IDLE, 0, 0, 0, 31, 16'h0020);
      addV(9, 0, 16'hFFFF, 0, 5, IDLE, 0, 0, 0, 31, 16'hFFFF);
      // detectQuiet with zero threshold follows the enables.
      addV(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 16'h0000);
      addV(0, 0, 16'hFFFF, 0, 0, 0, 0, 0, 0, 0, 16'hFFFF);

      reset = 1'b0;
      substate = '0; comparatorsCount = '0; resetOsCheckers = '0; osValid = '0;
      osType = '0; osLinkNum = '0; osLinkPad = '0; osLanePad = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_cnt", 128'(laneCount), 128'(0));
      check("reset_cmp", 128'(countersComparators), 128'(0));
      @(negedge clk);
      reset = 1'b1;

      foreach (vecs[k]) begin
         applyVec(vecs[k]);
         @(posedge clk);
         #1;
         check($sformatf("tbl%0d_cnt", k), 128'(laneCount[CW*vecs[k].lane +: CW]), 128'(vecs[k].expCnt));
         check($sformatf("tbl%0d_cmp", k), 128'(countersComparators), 128'(vecs[k].expBits));
      end

      // Resynchronise with the model through a reset, then random traffic.
      @(negedge clk);
      reset = 1'b0;
      resetModel();
      @(negedge clk);
      reset = 1'b1;
      substate = 4'd2;
      comparatorsCount = 5'd4;
      for (int c = 0; c < 3000; c++) randomCycle();

      // Asynchronous reset mid-cycle must clear outputs without a clock edge.
      #3;
      reset = 1'b0;
      #1;
      check("async_cnt", 128'(laneCount), 128'(0));
      check("async_cmp", 128'(countersComparators), 128'(0));
      resetModel();
      @(posedge clk);
      #1;
      compareModel("inreset");
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 500; c++) randomCycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lane_os_counter_bank.md
# lane_os_counter_bank

Per-lane bank of consecutive ordered-set counters that sits directly upstream of the master RX LTSSM. It watches decoded TS1/TS2/IDLE ordered sets on up to MAXLANES lanes, counts consecutive sets that qualify for the current LTSSM substate, and drives one comparator bit per lane. The bit is high when that lane's count has reached the threshold the LTSSM requests. The LTSSM consumes this vector as `countersComparators` and controls the bank through `resetOsCheckers` and `comparatorsCount`.

## Interface
- MAXLANES, 16, number of lane counters
- CNTW, 5, counter width; counters saturate at 2^CNTW-1
- clk  input  1  clock
- reset  input  1  asynchronous, active-low
- substate  input  4  LTSSM substate (0 detectQuiet … 9 configurationIdle)
- comparatorsCount  input  5  required consecutive-OS count
- resetOsCheckers  input  MAXLANES  per-lane run enable; 0 clears the lane's counter
- osValid  input  MAXLANES  one-cycle strobe per lane, one complete OS decoded
- osType  input  3*MAXLANES  lane i at [3i+2:3i]: 0 other, 1 TS1, 2 TS2, 3 SKP, 4 EIOS, 5 EIEOS, 6 IDLE
- osLinkNum  input  8*MAXLANES  link-number symbol of the OS
- osLinkPad  input  MAXLANES  link-number field is PAD
- osLanePad  input  MAXLANES  lane-number field is PAD
- countersComparators  output  MAXLANES  registered, lane count ≥ comparatorsCount
- laneCount  output  CNTW*MAXLANES  registered per-lane counts, for debug and coverage

## Operation
- **Per-lane state:** `cnt[CNTW]`, `linkCap[8]`. A shared `substateQ` register holds the previous substate.
- **Qualifying OS by substate:**
  - 2 pollingActive: TS1 or TS2, link PAD, lane PAD.
  - 3 pollingConfiguration: TS2, link PAD, lane PAD.
  - 4 linkWidthStart: TS1, link non-PAD, lane PAD.
  - 5 linkWidthAccept: TS1, link non-PAD, lane non-PAD.
  - 6, 7, 8 lanenumWait, lanenumAccept, configComplete: TS2, link non-PAD, lane non-PAD.
  - 9 configurationIdle: IDLE.
  - 0, 1, 10–15: no OS qualifies.
- **Per-lane update priority (highest first):**
  1. `resetOsCheckers[i]`=0, or `substate`≠`substateQ`: `cnt`←0.
  2. `osValid[i]`=0: hold.
  3. osType SKP or EIEOS: hold. These are transparent interleaves.
  4. Qualifying OS in substates 4–8:
     - `cnt`=0, or `osLinkNum`≠`linkCap`: `cnt`←1 and `linkCap`←`osLinkNum`. A new link number restarts the consecutive run.
     - Otherwise `cnt`←sat(`cnt`+1).
  5. Qualifying OS in other substates: `cnt`←sat(`cnt`+1).
  6. Any other valid OS, including EIOS: `cnt`←0.
- **Saturation:** `cnt` never wraps; it holds at 2^CNTW-1 (31).
- **Comparator:** `countersComparators[i]` ← `resetOsCheckers[i]` && (`cnt_next` ≥ `comparatorsCount`). The compare is unsigned, with `comparatorsCount` zero-extended or truncated to CNTW.
  - When `comparatorsCount`=0, the bit is 1 on every enabled cycle. This covers the detect substates.
- **Lane independence:** lanes have no interaction; only `substate`, `comparatorsCount` and `substateQ` are shared.

## Timing
- **Reset values:** `cnt`, `linkCap`, `laneCount` and `countersComparators` all 0. `substateQ`=4'hF, so the first substate after reset clears counters.
- **Latency:** an OS strobed at edge N updates `laneCount` and `countersComparators` at edge N+1. The comparator is computed from the next-count value, so it adds no extra cycle.
- **Clear:** `resetOsCheckers[i]` low at edge N gives count 0 and comparator 0 at N+1. A strobe in the same cycle is discarded.
- **Substate change:** all counters clear at the edge where the mismatch is sampled. Strobes in that cycle are discarded. Counting resumes the following cycle.
- **Threshold change:** a new `comparatorsCount` takes effect at the next edge with no count change.
- **Mid-operation reset:** asynchronous assertion forces all reset values immediately.

## Test plan
- **pollingActive threshold:** substate=2, enable all lanes, count=8, 8 TS1 PAD/PAD strobes on lane 3 → lane 3 count=8 and bit 3=1 exactly one cycle after the 8th strobe; other bits stay 0.
- **Run-breaking and transparent sets:**
  - substate=3, lane 0 gets 5 TS2, 1 TS1, 3 TS2 → count=3, bit 0=0 at count=8.
  - Interleaved SKP and EIEOS → count unaffected.
- **Link-number restart:** substate=5, lane 1 gets TS1 link=7 ×1, then link=9 ×2 → count=2, `linkCap`=9. Count=2 → bit 1=1.
- **Clear and substate change:**
  - `resetOsCheckers[2]`=0 during a strobe → count 0 next cycle.
  - Substate 4→5 with counts at 2 → all counts 0 and all bits 0 (count=2).
- **Saturation and detect:**
  - 40 IDLE strobes in substate 9 → count=31, bit=1 (count=8).
  - substate=0, count=0, enables=1 → all bits 1 one cycle after enable.
  - Async reset asserted mid-run → all outputs 0 immediately.
